// File: rtl/fetch_basic.sv
// fetch_basic: in-order single-issue fetch unit. Issues sequential PC requests
// to instruction memory, pairs in-order responses with their PCs and hands
// (pc, inst) to decode. Squashes flip a one-bit epoch so that responses already
// in flight are recognised as stale and dropped.
module fetch_basic #(
   parameter int unsigned p_addr_bits      = 32,
   parameter int unsigned p_inst_bits      = 32,
   parameter logic [p_addr_bits-1:0] p_rst_addr = p_addr_bits'(32'h200),
   parameter int unsigned p_max_in_flight  = 2
) (
   input  logic                   clk,
   input  logic                   rst,

   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [p_addr_bits-1:0] mem_req_addr,

   input  logic                   mem_resp_val,
   output logic                   mem_resp_rdy,
   input  logic [p_inst_bits-1:0] mem_resp_data,

   output logic                   d_val,
   input  logic                   d_rdy,
   output logic [p_inst_bits-1:0] d_inst,
   output logic [p_addr_bits-1:0] d_pc,
   input  logic                   d_squash,
   input  logic [p_addr_bits-1:0] d_branch_target
);

   localparam int unsigned PTR_W = $clog2(p_max_in_flight);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Architectural state
   logic [p_addr_bits-1:0] pc;
   logic                   epoch;
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [CNT_W-1:0]       count;

   // In-flight queue storage: PC and epoch of every outstanding request
   logic [p_addr_bits-1:0] q_pc [p_max_in_flight];
   logic                   q_ep [p_max_in_flight];

   // Handshake and control terms
   logic                   q_empty;
   logic                   stale;
   logic                   enq;
   logic                   deq;
   logic                   epoch_next;
   logic [p_addr_bits-1:0] pc_next;

   // Response side: drop stale heads, otherwise pass live responses to decode
   always_comb begin
      q_empty      = (count == '0);
      stale        = (q_ep[head] != epoch) | d_squash;
      mem_resp_rdy = 1'b0;
      d_val        = 1'b0;
      d_inst       = mem_resp_data;
      d_pc         = q_pc[head];
      if (!q_empty) begin
         if (stale) begin
            mem_resp_rdy = 1'b1;
         end else begin
            mem_resp_rdy = d_rdy;
            d_val        = mem_resp_val;
         end
      end
      deq = mem_resp_val & mem_resp_rdy;
   end

   // Request side: issue while there is queue space or a slot frees this cycle
   always_comb begin
      mem_req_val  = (count < CNT_W'(p_max_in_flight)) | deq;
      mem_req_addr = d_squash ? d_branch_target : pc;
      enq          = mem_req_val & mem_req_rdy;
      epoch_next   = d_squash ? ~epoch : epoch;
      pc_next      = pc;
      if (enq) begin
         pc_next = mem_req_addr + p_addr_bits'(4);
      end else if (d_squash) begin
         pc_next = d_branch_target;
      end
   end

   // PC, epoch and queue pointer/count update
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= p_rst_addr;
         epoch <= 1'b0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         pc    <= pc_next;
         epoch <= epoch_next;
         if (enq) begin
            tail <= tail + PTR_W'(1);
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue payload write; contents are only meaningful below count
   always_ff @(posedge clk) begin
      if (enq) begin
         q_pc[tail] <= mem_req_addr;
         q_ep[tail] <= epoch_next;
      end
   end

   // A response with nothing outstanding means the memory broke ordering
   resp_without_req : assert property (@(posedge clk) disable iff (rst)
      !(mem_resp_val && (count == '0)));

endmodule

// File: doc/fetch_basic.md
# fetch_basic

In-order, single-issue fetch unit that drives the fetch side of the F→D interface. It generates sequential PCs and issues instruction-memory requests. It pairs each in-order memory response with its PC and presents the (pc, inst) pair to decode under val/rdy. On a squash from downstream, it redirects to a branch target and discards every stale in-flight response, tagging each outstanding request with a one-bit epoch.

## Interface
- p_addr_bits, 32, PC/address width
- p_inst_bits, 32, instruction width
- p_rst_addr, 32'h200, first PC fetched after reset
- p_max_in_flight, 2, depth of the in-flight queue (power of two, ≥2)

- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  p_addr_bits  fetch address
- mem_resp_val  in  1  memory response valid; responses return in request order
- mem_resp_rdy  out  1  fetch accepts response
- mem_resp_data  in  p_inst_bits  instruction word
- D.val  out  1  (pc, inst) valid to decode
- D.rdy  in  1  decode accepts
- D.inst  out  p_inst_bits  instruction
- D.pc  out  p_addr_bits  PC of inst
- D.squash  in  1  redirect request from downstream
- D.branch_target  in  p_addr_bits  redirect PC, valid when D.squash=1

## Operation
- State:
  - pc register
  - epoch bit
  - circular in-flight queue of {pc, epoch} with head/tail pointers and a count of 0..p_max_in_flight
- Request issue:
  - mem_req_val = (count < p_max_in_flight) | deq, where deq = mem_resp_val & mem_resp_rdy.
  - mem_req_addr = D.squash ? D.branch_target : pc.
  - On req xfer: enqueue {mem_req_addr, epoch_next}, then pc ← mem_req_addr + 4. Addition is modulo 2^p_addr_bits; wrap-around is silent.
- Response handling:
  - Head entry pairs with mem_resp_data.
  - The response is stale if head.epoch ≠ epoch, or if D.squash=1 this cycle.
  - Stale: mem_resp_rdy=1, D.val=0, entry dequeued and dropped.
  - Live: D.val=mem_resp_val, D.inst=mem_resp_data, D.pc=head.pc, mem_resp_rdy=D.rdy; dequeue on xfer.
  - Queue empty: mem_resp_rdy=0, D.val=0. A response arriving with the queue empty is a protocol error (assertion).
- Squash:
  - epoch ← ~epoch.
  - If no req xfer the same cycle, pc ← D.branch_target.
  - If req xfers the same cycle, the request uses branch_target with the new epoch, and pc ← branch_target+4.
  - Repeated squashes in consecutive cycles are legal; the last one wins.
- Simultaneous enqueue and dequeue with the queue full is legal; count stays unchanged.
- Outputs are combinational from state and inputs; there are no registered outputs besides pc, epoch and the queue.

## Timing
- Reset values:
  - pc=p_rst_addr, epoch=0, count=0, head=tail=0
  - D.val=0; mem_req_val=1 combinationally from the first cycle rst=0; mem_resp_rdy=0
- Latency: request at cycle t with a 1-cycle memory gives D.val at t+1 (same cycle the response arrives).
- Throughput: 1 inst/cycle with a 1-cycle memory and D.rdy=1.
- Back-pressure:
  - D.rdy=0 stalls the head response (mem_resp_rdy=0).
  - Requests continue until the queue is full.
  - D.inst/D.pc hold stable while D.val=1 and D.rdy=0, provided memory holds the response.
- rst asserted mid-operation: the queue is flushed next edge, and outstanding memory responses must be discarded by the memory itself. The unit returns to p_rst_addr with epoch=0.
- Combinational paths:
  - D.rdy → mem_resp_rdy → mem_req_val
  - D.squash → mem_req_addr, D.val
  - There must be no path from mem_req_rdy to D outputs.

## Test plan
- Reset, always-ready 1-cycle memory, D.rdy=1 → requests 0x200,0x204,0x208…; D.pc matches one cycle later, D.inst = mem word; one valid per cycle.
- D.rdy=0 for 5 cycles after the first response → D.pc held at 0x200; exactly 2 requests outstanding; no further mem_req xfer; resumes 0x204, 0x208 in order.
- Squash to 0x1000 with 2 in flight (0x208, 0x20C) → both responses consumed with D.val=0; next D.pc=0x1000, then 0x1004.
- Squash in the same cycle a live response arrives → that response is dropped; the same-cycle request goes to branch_target.
- Memory with 3-cycle latency and mem_req_rdy toggling → D.pc strictly sequential, no duplicates or gaps; count never exceeds p_max_in_flight.
- PC at 0xFFFFFFFC → next request 0x00000000; rst asserted mid-stream → next request 0x200, D.val=0 until its response.
